reset_sequencer: RTL and testbench

- Top-level reset controller that sequences reset release across NUM_DOMAINS downstream clock-domain reset synchronizers after PLL lock.
- Waits for a stable lock, then releases domain resets in a fixed order with programmable spacing.
- Re-asserts every domain on lock loss.
- Provides a request/acknowledge soft-reset path for software or debug logic.
- Sits between the PLL and the per-domain active-low reset synchronizers.

---
 rtl/reset_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Sequences reset release of NUM_DOMAINS clock domains after a stable PLL lock,
// with lock-loss re-assertion and a soft-reset handshake. RST_SEQ_TIMEOUT_EN adds PLL retry.
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int NUM_DOMAINS  = 3,
    parameter int STAGE_DELAY  = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int SOFT_HOLD    = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pll_lock,
    input  logic                   sw_reset_req,
    output logic                   sw_reset_ack,
    output logic [NUM_DOMAINS-1:0] domain_reset_n,
    output logic                   seq_done,
    output logic                   pll_reset,
    output logic                   lock_timeout
);

    // state     | meaning
    // HOLD      | reset just released, all domains held
    // WAIT_LOCK | waiting for synchronized PLL lock
    // STABLE    | counting LOCK_STABLE consecutive locked cycles
    // RELEASE   | releasing domains one by one, STAGE_DELAY apart
    // RUN       | all domains released
    // SOFT      | soft reset, all domains held for SOFT_HOLD cycles
    typedef enum logic [2:0] {
        S_HOLD, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN, S_SOFT
    } state_t;

    localparam int CNT_MAX_A = (LOCK_STABLE > STAGE_DELAY) ? LOCK_STABLE : STAGE_DELAY;
    localparam int CNT_MAX   = (CNT_MAX_A > SOFT_HOLD) ? CNT_MAX_A : SOFT_HOLD;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int IDX_W     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [NUM_DOMAINS-1:0] DOM_FIRST = NUM_DOMAINS'(1);

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || STAGE_DELAY < 1 || LOCK_STABLE < 1 ||
        SOFT_HOLD < 1 || LOCK_TIMEOUT < 1) begin : g_param_check
        $error("reset_sequencer: illegal parameter value");
    end

    state_t                   state, state_n;
    logic [CNT_W-1:0]         cnt, cnt_n;
    logic [IDX_W-1:0]         idx, idx_n;
    logic [NUM_DOMAINS-1:0]   dom_n;
    logic                     done_n;
    logic                     ack_n;
    logic                     lock_meta, lock_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_HOLD;
            cnt            <= '0;
            idx            <= '0;
            domain_reset_n <= '0;
            seq_done       <= 1'b0;
            sw_reset_ack   <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            idx            <= idx_n;
            domain_reset_n <= dom_n;
            seq_done       <= done_n;
            sw_reset_ack   <= ack_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        dom_n   = domain_reset_n;
        done_n  = seq_done;
        ack_n   = 1'b0;
        case (state)
            S_HOLD: begin
                state_n = S_WAIT_LOCK;
                cnt_n   = '0;
                dom_n   = '0;
                done_n  = 1'b0;
            end
            S_WAIT_LOCK: begin
                cnt_n  = '0;
                dom_n  = '0;
                done_n = 1'b0;
                if (lock_s) state_n = S_STABLE;
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                    dom_n   = '0;
                    done_n  = 1'b0;
                end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
                    cnt_n = '0;
                    idx_n = '0;
                    dom_n = DOM_FIRST;
                    if (NUM_DOMAINS == 1) begin
                        state_n = S_RUN;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_RELEASE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                    dom_n   = '0;
                    done_n  = 1'b0;
                end else if (cnt == CNT_W'(STAGE_DELAY - 1)) begin
                    // domains are released strictly in order, so shifting in a one
                    // releases bit idx+1
                    cnt_n = '0;
                    idx_n = idx + IDX_W'(1);
                    dom_n = (domain_reset_n << 1) | DOM_FIRST;
                    if (idx == IDX_W'(NUM_DOMAINS - 2)) begin
                        state_n = S_RUN;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                    dom_n   = '0;
                    done_n  = 1'b0;
                end else if (sw_reset_req) begin
                    state_n = S_SOFT;
                    cnt_n   = '0;
                    dom_n   = '0;
                    done_n  = 1'b0;
                    ack_n   = 1'b1;
                end
            end
            S_SOFT: begin
                if (cnt == CNT_W'(SOFT_HOLD - 1)) begin
                    cnt_n   = '0;
                    state_n = lock_s ? S_STABLE : S_WAIT_LOCK;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_HOLD;
                cnt_n   = '0;
                dom_n   = '0;
                done_n  = 1'b0;
            end
        endcase
    end

`ifdef RST_SEQ_TIMEOUT_EN
    localparam int TCNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic [TCNT_W-1:0] tcnt;
    logic [1:0]        pcnt;
    logic              timeout_hit;

    assign timeout_hit = (state == S_WAIT_LOCK) && (tcnt == TCNT_W'(LOCK_TIMEOUT - 1));

    // pll_reset stays high for the hit cycle plus three more
    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt         <= '0;
            pcnt         <= '0;
            pll_reset    <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            tcnt <= (state == S_WAIT_LOCK && !timeout_hit) ? tcnt + TCNT_W'(1) : '0;
            if (timeout_hit) begin
                pll_reset    <= 1'b1;
                pcnt         <= 2'd3;
                lock_timeout <= 1'b1;
            end else if (pcnt != 2'd0) begin
                pcnt <= pcnt - 2'd1;
            end else begin
                pll_reset <= 1'b0;
            end
        end
    end
`else
    assign pll_reset    = 1'b0;
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (default parameters, timeout feature off).
`timescale 1ns/1ps

module tb_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       sw_reset_req;
    logic       sw_reset_ack;
    logic [2:0] domain_reset_n;
    logic       seq_done;
    logic       pll_reset;
    logic       lock_timeout;

    int total = 0;
    int bad   = 0;
    int n;

    reset_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .pll_lock       (pll_lock),
        .sw_reset_req   (sw_reset_req),
        .sw_reset_ack   (sw_reset_ack),
        .domain_reset_n (domain_reset_n),
        .seq_done       (seq_done),
        .pll_reset      (pll_reset),
        .lock_timeout   (lock_timeout)
    );

    always #5 clock = ~clock;

    task automatic tick(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // edges until domain_reset_n matches target, bounded at 300
    task automatic wait_dom(input logic [2:0] target, output int edges);
        edges = 0;
        while (domain_reset_n !== target && edges < 300) begin
            @(posedge clock);
            #1;
            edges++;
        end
    endtask

    task automatic finish_release(input string tag);
        int e;
        wait_dom(3'b011, e);
        check({tag, "_d1_gap"}, e, 16);
        check({tag, "_done_mid"}, seq_done, 0);
        wait_dom(3'b111, e);
        check({tag, "_d2_gap"}, e, 16);
        check({tag, "_done"}, seq_done, 1);
    endtask

    initial begin
        reset        = 1'b1;
        pll_lock     = 1'b0;
        sw_reset_req = 1'b0;
        tick(3);
        check("rst_dom", domain_reset_n, 3'b000);
        check("rst_done", seq_done, 0);
        check("rst_ack", sw_reset_ack, 0);
        check("rst_pll_reset", pll_reset, 0);
        check("rst_lock_timeout", lock_timeout, 0);

        // power-up: reset drops at cycle 0, lock at cycle 10, domain 0 at 77
        reset = 1'b0;
        tick(10);
        pll_lock = 1'b1;
        wait_dom(3'b001, n);
        check("pwr_d0_time", n, 67);
        check("pwr_done_d0", seq_done, 0);
        finish_release("pwr");

        // lock loss in RUN: outputs drop on the third edge
        pll_lock = 1'b0;
        tick(2);
        check("loss_dom_edge2", domain_reset_n, 3'b111);
        tick(1);
        check("loss_dom_edge3", domain_reset_n, 3'b000);
        check("loss_done", seq_done, 0);
        pll_lock = 1'b1;
        wait_dom(3'b001, n);
        check("relock_d0_time", n, 67);
        finish_release("relock");

        // lock glitch 40 cycles into STABLE restarts the full window
        pll_lock = 1'b0;
        tick(3);
        pll_lock = 1'b1;
        tick(43);
        pll_lock = 1'b0;
        tick(3);
        check("glitch_dom", domain_reset_n, 3'b000);
        pll_lock = 1'b1;
        wait_dom(3'b001, n);
        check("glitch_d0_time", n, 67);
        finish_release("glitch");

        // soft reset from RUN
        sw_reset_req = 1'b1;
        tick(1);
        check("soft_ack", sw_reset_ack, 1);
        check("soft_dom", domain_reset_n, 3'b000);
        check("soft_done", seq_done, 0);
        sw_reset_req = 1'b0;
        tick(1);
        check("soft_ack_once", sw_reset_ack, 0);
        wait_dom(3'b001, n);
        check("soft_d0_time", n, 71);
        finish_release("soft");

        // lock loss visible in the same cycle as a request: no ack
        pll_lock = 1'b0;
        tick(2);
        sw_reset_req = 1'b1;
        tick(1);
        check("race_ack", sw_reset_ack, 0);
        check("race_dom", domain_reset_n, 3'b000);

        // request held in WAIT_LOCK is never acked
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("wait_req_ack", sw_reset_ack, 0);
        end
        sw_reset_req = 1'b0;
        pll_lock     = 1'b1;
        wait_dom(3'b001, n);
        check("wait_d0_time", n, 67);

        // reset mid-RELEASE clears everything, then the sequence restarts
        wait_dom(3'b011, n);
        check("midrst_d1_gap", n, 16);
        reset = 1'b1;
        tick(1);
        check("midrst_dom", domain_reset_n, 3'b000);
        check("midrst_done", seq_done, 0);
        tick(1);
        check("midrst_hold_dom", domain_reset_n, 3'b000);
        reset = 1'b0;
        wait_dom(3'b001, n);
        check("midrst_d0_time", n, 67);
        finish_release("midrst");

        check("end_pll_reset", pll_reset, 0);
        check("end_lock_timeout", lock_timeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
